// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed big-endian byte image into the instruction memory write port; define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              regWE,
  output logic [ADDR_W-1:0] Addr,
  output logic [31:0]       DataIn,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    WORD,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } state_t;
  localparam logic [16:0] MAX_L = 17'(MAX_WORDS);
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [23:0] asm_q, asm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic we_q, we_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic acc, last;
  logic [16:0] n_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  assign acc = byteValid && ready_q;
  assign last = (cnt_q + 16'd1) == len_q;
  assign n_len = {1'b0, len_q[15:8], byteIn};
  // next-state logic; the status outputs are derived from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    asm_d = asm_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: if (start) begin
        state_d = LEN_HI;
        addr_d = '0;
        cnt_d = '0;
      end
      LEN_HI: if (acc) begin
        len_d = {byteIn, len_q[7:0]};
        state_d = LEN_LO;
      end
      LEN_LO: if (acc) begin
        len_d = n_len[15:0];
        idx_d = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = 8'd0;
`endif
        state_d = (n_len == 17'd0 || n_len > MAX_L) ? ERR : WORD;
      end
      WORD: if (acc) begin
        asm_d = {asm_q[15:0], byteIn};
        idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ byteIn;
`endif
        if (idx_q == 2'd3) begin
          we_d = 1'b1;
          data_d = {asm_q, byteIn};
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d = cnt_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_d = last ? CHECK : WORD;
`else
        state_d = last ? DONE : WORD;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: if (acc) state_d = (byteIn == csum_q) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_d = state_d inside {LEN_HI, LEN_LO, WORD, CHECK};
`else
    ready_d = state_d inside {LEN_HI, LEN_LO, WORD};
`endif
    busy_d = !(state_d inside {IDLE, DONE, ERR});
    done_d = state_d == DONE;
    err_d = state_d == ERR;
  end
  // state and registered outputs; reset discards any partially assembled word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      asm_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      asm_q <= asm_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
  assign byteReady = ready_q;
  assign regWE = we_q;
  assign Addr = addr_q;
  assign DataIn = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; expected writes are queued by stimulus and popped by a write monitor
module tb_imem_loader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, byteValid = 1'b0;
  logic [7:0] byteIn = 8'd0;
  logic byteReady, regWE, busy, done, error;
  logic [9:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] tb_mem [0:1023];
  logic [41:0] exp_q [$];
  int checks = 0, errors = 0, we_cnt = 0;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .regWE(regWE), .Addr(Addr), .DataIn(DataIn),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // instruction memory model fed by the DUT write port
  always @(posedge clk) if (regWE) tb_mem[Addr] <= DataIn;

  // write monitor: every write the DUT presents must match the head of the queue
  always @(negedge clk) begin
    logic [41:0] e;
    if (!reset && regWE) begin
      we_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0h data=%08h, required no write", Addr, DataIn);
      end else begin
        e = exp_q.pop_front();
        if ({Addr, DataIn} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h", Addr, DataIn, e[41:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    byteIn = b;
    byteValid = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      if (byteReady) break;
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %02h never accepted", b);
    end
    @(posedge clk); #1;
    if (gap) begin
      byteValid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy stuck high");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_image(input logic [7:0] img [], input bit gap, input int mid_start);
    for (int i = 0; i < img.size(); i++) begin
      send(img[i], gap);
      if (i == mid_start) begin
        byteValid = 1'b0;
        pulse_start();
      end
    end
    byteValid = 1'b0;
  endtask

  initial begin
    logic [7:0] img_a [] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    logic [7:0] img_b [] = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] img_r [] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE};
    int w0;
    #1;
    chk("rst_ready", byteReady, 0); chk("rst_we", regWE, 0); chk("rst_addr", Addr, 0);
    chk("rst_data", DataIn, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", error, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    // N=2 with continuous valid
    pulse_start();
    chk("start_busy", busy, 1); chk("start_ready", byteReady, 1);
    exp_q.push_back({10'd0, 32'hDEADBEEF});
    exp_q.push_back({10'd1, 32'h01234567});
    w0 = we_cnt;
    send_image(img_a, 1'b0, -1);
    wait_idle();
    chk("a_done", done, 1); chk("a_err", error, 0); chk("a_addr", Addr, 2); chk("a_ready", byteReady, 0);
    chk("a_we_cycles", we_cnt - w0, 2);
    chk("a_mem0", tb_mem[0], 32'hDEADBEEF); chk("a_mem1", tb_mem[1], 32'h01234567);
`ifndef IMEM_LOADER_CHECKSUM_EN
    byteIn = 8'hAA;
    byteValid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("extra_ready", byteReady, 0); chk("extra_done", done, 1);
    byteValid = 1'b0;
`endif
    // zero-length header
    w0 = we_cnt;
    pulse_start();
    chk("z_done_clr", done, 0); chk("z_addr", Addr, 0);
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    byteValid = 1'b0;
    chk("z_err", error, 1); chk("z_ready", byteReady, 0); chk("z_busy", busy, 0);
    // oversize header 1025
    pulse_start();
    chk("o_err_clr", error, 0);
    send(8'h04, 1'b0); send(8'h01, 1'b0);
    byteValid = 1'b0;
    @(posedge clk); #1;
    chk("o_err", error, 1); chk("o_ready", byteReady, 0); chk("hdr_no_we", we_cnt - w0, 0);
    // N=2 with toggling valid and a start pulse mid-load
    pulse_start();
    exp_q.push_back({10'd0, 32'hCAFEBABE});
    exp_q.push_back({10'd1, 32'h12345678});
    send_image(img_b, 1'b1, 3);
    wait_idle();
    chk("b_done", done, 1); chk("b_addr", Addr, 2);
    chk("b_mem0", tb_mem[0], 32'hCAFEBABE); chk("b_mem1", tb_mem[1], 32'h12345678);
    // reset after the 6th byte once word 0 has been written
    pulse_start();
    exp_q.push_back({10'd0, 32'hDEADBEEF});
    send_image(img_r, 1'b0, -1);
    send(8'hEF, 1'b1);
    reset = 1'b1;
    #1;
    chk("mr_ready", byteReady, 0); chk("mr_we", regWE, 0); chk("mr_addr", Addr, 0);
    chk("mr_data", DataIn, 0); chk("mr_busy", busy, 0);
    chk("mr_done", done, 0); chk("mr_err", error, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_mem0", tb_mem[0], 32'hDEADBEEF); chk("mr_mem1", tb_mem[1], 32'h12345678);
`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    exp_q.push_back({10'd0, 32'h11223344});
    send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0);
    send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'h44, 1'b0);
    byteValid = 1'b0;
    wait_idle();
    chk("cs_ok_done", done, 1); chk("cs_ok_err", error, 0);
    pulse_start();
    exp_q.push_back({10'd0, 32'h11223344});
    send(8'h00, 1'b0); send(8'h01, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0);
    send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'h45, 1'b0);
    byteValid = 1'b0;
    wait_idle();
    chk("cs_bad_err", error, 1); chk("cs_bad_done", done, 0); chk("cs_bad_mem0", tb_mem[0], 32'h11223344);
`endif
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Streams a program image into the 1024×32 instruction memory through its synchronous write port (regWE/Addr/DataIn), so the core can be reprogrammed without rebuilding the `$readmemb` image. It accepts a byte stream with a valid/ready handshake, validates a length header, assembles big-endian 32-bit words, and issues one memory write per word. It sits between the host byte link and the instruction memory write port. The instruction memory's combinational read port is untouched.

## Interface
- `ADDR_W`, default 10: instruction memory address width.
- `MAX_WORDS`, default 1024: largest accepted image length in words. Must be ≤ 2^ADDR_W.

- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request to begin a load. Sampled only in IDLE, DONE or ERR.
- `byteIn` input 8: incoming stream byte.
- `byteValid` input 1: `byteIn` is valid.
- `byteReady` output 1: the loader accepts a byte this cycle.
- `regWE` output 1: memory write enable. Registered.
- `Addr` output ADDR_W: memory write address. Registered.
- `DataIn` output 32: memory write data. Registered.
- `busy` output 1: a load is in progress.
- `done` output 1: sticky; the last load completed successfully.
- `error` output 1: sticky; the last load was aborted.

## Operation
- A byte is accepted on a rising edge where `byteValid && byteReady` are both high. Bytes are never consumed otherwise.
- Stream format:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N×4 payload bytes, each word most-significant byte first.
  - A checksum byte, only when the checksum feature is enabled (see Configuration).
- States and transitions:
  - IDLE: `start` clears `done`/`error`, clears `Addr` and the word counter, then goes to LEN_HI.
  - LEN_HI: accept a byte → LEN_LO.
  - LEN_LO: accept a byte → validate N.
    - N == 0 or N > MAX_WORDS → ERR.
    - Otherwise → WORD with byte index 0.
  - WORD: each accepted byte shifts into the assembly register. The 4th byte → WRITE.
  - WRITE: `regWE`=1 for exactly one cycle, with `DataIn` = assembled word and `Addr` = current word index.
    - On exit `Addr` increments.
    - If this was word N → CHECK (checksum enabled) or DONE; otherwise → WORD.
  - DONE: `done`=1. `start` → LEN_HI as from IDLE.
  - ERR: `error`=1. `start` → LEN_HI as from IDLE.
- `byteReady` = 1 in LEN_HI, LEN_LO, WORD and CHECK; 0 in IDLE, WRITE, DONE and ERR.
- `busy` = 1 in every state except IDLE, DONE and ERR.
- `start` while busy is ignored.
- Address arithmetic:
  - `Addr` is ADDR_W bits and never wraps during a valid load, because N ≤ MAX_WORDS.
  - After DONE, `Addr` holds N mod 2^ADDR_W.
- Reset mid-load:
  - All state and outputs return to reset values immediately.
  - Words already written remain in memory.
  - A partially assembled word is discarded and never written.

## Timing
- Reset values: `byteReady`=0, `regWE`=0, `Addr`=0, `DataIn`=0, `busy`=0, `done`=0, `error`=0; state IDLE.
- `start` high at edge k → `busy`=1 and `byteReady`=1 from edge k onward.
- 4th payload byte accepted at edge t:
  - `regWE`=1 during cycle t..t+1; memory captures the word at edge t+1.
  - `byteReady` is 0 for that one cycle and returns to 1 after edge t+1.
- Minimum load time is 2 + 5N cycles (header, 4 bytes plus 1 write cycle per word), plus 1 cycle for the checksum byte when enabled.
- `done`/`error` assert on the edge that enters DONE/ERR and hold until the next accepted `start` or `reset`.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After word N, state CHECK accepts one byte.
  - If that byte equals the XOR of all 4N payload bytes → DONE; otherwise → ERR.
  - Memory has already been written in either case.
- Undefined:
  - No CHECK state and no checksum byte; WRITE of word N goes directly to DONE.
  - Any extra byte is left unaccepted (`byteReady`=0).

## Test plan
- N=2 load, bytes 00 02 DE AD BE EF 01 23 45 67, `byteValid` always high → writes 0xDEADBEEF at Addr 0 and 0x01234567 at Addr 1, `regWE` high exactly 2 cycles, `done`=1, `Addr`=2.
- Header 00 00, and separately header 04 01 (1025) → ERR after LEN_LO, `error`=1, `regWE` never asserted, `byteReady`=0.
- `byteValid` toggling every other cycle during the N=2 load → identical memory contents; no byte lost or duplicated.
- `reset` asserted after the 6th byte of the N=2 load → all outputs are reset values immediately; mem[0]=0xDEADBEEF retained, mem[1] unchanged.
- `start` pulsed while busy → ignored, load completes normally. `start` in DONE → `done` clears and a second load begins at Addr 0.
- With `IMEM_LOADER_CHECKSUM_EN`, N=1 word 11 22 33 44: checksum 0x44 → DONE; checksum 0x45 → ERR with mem[0]=0x11223344.
